vector_fetch_arb: RTL
=====================

VECTOR_FETCH_ARB -- requirements
Module: vector_fetch_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, WAIT cycles without read data before a fetch is abandoned.
REQ-002 Parameter TO_CNT_W, default 8, width of timeout counter; SHALL satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run_en  input  1  program running; gates program requests.
REQ-006 prog_req  input  1  program-sequencer fetch request, level, held until prog_gnt.
REQ-007 prog_addr  input  32  program fetch address.
REQ-008 prog_gnt  output  1  one-cycle grant pulse to program sequencer.
REQ-009 host_req  input  1  host (slave-side) read request, level, held until host_gnt.
REQ-010 host_addr  input  32  host read address.
REQ-011 host_gnt  output  1  one-cycle grant pulse to host.
REQ-012 master_addr  output  32  read address to master port.
REQ-013 master_rd  output  1  one-cycle read strobe.
REQ-014 master_data_in  input  32  returned read data.
REQ-015 master_data_in_val  input  1  returned data valid.
REQ-016 vctr_fifo_almost_full  input  1  vector FIFO back-pressure.
REQ-017 vctr_fifo_wr  output  1  vector FIFO write strobe.
REQ-018 vctr_fifo_din  output  32  vector FIFO write data.
REQ-019 host_rdata_val / host_err / host_rdata  output  1/1/32  host read completion, error flag, data.
REQ-020 clear_err  input  1  clears timeout_err.
REQ-021 timeout_err  output  1  sticky timeout flag.
REQ-022 prog_fetch_cnt  output  16  completed program fetches.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT; one outstanding read at most.
REQ-024 Eligibility: prog_elig = prog_req & run_en & ~vctr_fifo_almost_full; host_elig = host_req.
REQ-025 IDLE: if any requester eligible, SHALL latch winner's address and owner, go to ISSUE next cycle; else stay.
REQ-026 Arbitration round-robin: if both eligible, winner is the one not granted last; last_gnt updated on every grant.
REQ-027 ISSUE (exactly one cycle): master_rd=1, master_addr=latched address, winner's gnt=1; next state WAIT.
REQ-028 WAIT: timeout counter increments each cycle from 0; master_data_in_val=1 completes the fetch, returns to IDLE.
REQ-029 Program completion: next cycle vctr_fifo_wr=1 for one cycle, vctr_fifo_din=captured data, prog_fetch_cnt+1 (wraps 0xFFFF->0x0000).
REQ-030 Host completion: next cycle host_rdata_val=1 for one cycle, host_rdata=captured data, host_err=0.
REQ-031 Timeout: counter reaching TIMEOUT_CYCLES without data SHALL set timeout_err, return to IDLE; program: no FIFO write, no count; host: host_rdata_val=1, host_err=1, host_rdata=0.
REQ-032 Data valid arriving on the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as completion, not timeout.
REQ-033 master_data_in_val outside WAIT SHALL be ignored.
REQ-034 almost_full or run_en changes after grant SHALL NOT abort an issued fetch.
REQ-035 clear_err clears timeout_err next cycle; simultaneous set and clear: set wins.
REQ-036 master_addr holds last issued address outside ISSUE; all strobes 0 outside their defined cycle.

Reset
REQ-037 reset SHALL force IDLE, last_gnt=host (program wins first tie), counters 0, timeout_err 0, all strobes 0, all data/address outputs 0.
REQ-038 reset asserted mid-WAIT SHALL abandon the fetch with no completion pulse; data arriving after reset is ignored.

Verification
REQ-039 prog_req=1, run_en=1, addr 0x100, data 0xA5A5A5A5 three cycles after master_rd -> one master_rd, then vctr_fifo_wr with 0xA5A5A5A5, prog_fetch_cnt=1.
REQ-040 prog_req and host_req both held after reset -> grants alternate prog, host, prog, host; four master_rd pulses.
REQ-041 prog_req=1 with vctr_fifo_almost_full=1 and host_req=0 -> no master_rd; deassert almost_full -> grant in IDLE next cycle.
REQ-042 host read, no data for 255 WAIT cycles -> host_rdata_val=1, host_err=1, host_rdata=0, timeout_err=1; clear_err -> 0.
REQ-043 data valid on exactly the 255th WAIT cycle -> normal completion, timeout_err stays 0.
REQ-044 reset during WAIT, data returned one cycle later -> no vctr_fifo_wr, no host_rdata_val, state IDLE.

Source files
------------

// File: rtl/vector_fetch_arb.sv
// ---------------------------------------------------------------------------
// vector_fetch_arb
//
// Purpose:
//   Arbitrates one shared read master port between two requesters:
//     - the program sequencer, which fetches vector words into the vector FIFO
//     - the host (slave side), which performs single read transactions
//   At most one read is outstanding. Each fetch takes the path
//   IDLE -> ISSUE -> WAIT -> IDLE. A fetch that receives no read data within
//   TIMEOUT_CYCLES WAIT cycles is abandoned, and the sticky timeout_err flag
//   is raised.
//
// Ports:
//   clk, reset              - single rising-edge clock, synchronous active-high reset
//   run_en                  - program running; gates program requests
//   prog_req/prog_addr      - program fetch request (level) and address
//   prog_gnt                - one-cycle grant pulse to the program sequencer
//   host_req/host_addr      - host read request (level) and address
//   host_gnt                - one-cycle grant pulse to the host
//   master_addr/master_rd   - read address and one-cycle read strobe to the master port
//   master_data_in(_val)    - returned read data and its valid qualifier
//   vctr_fifo_almost_full   - vector FIFO back-pressure (blocks program requests)
//   vctr_fifo_wr/_din       - vector FIFO write strobe and data
//   host_rdata_val/_err/    - host read completion pulse, error flag and data
//   host_rdata
//   clear_err/timeout_err   - clear input and sticky timeout flag
//   prog_fetch_cnt          - number of completed program fetches (wraps)
// ---------------------------------------------------------------------------
module vector_fetch_arb #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        prog_req,
  input  logic [31:0] prog_addr,
  output logic        prog_gnt,
  input  logic        host_req,
  input  logic [31:0] host_addr,
  output logic        host_gnt,
  output logic [31:0] master_addr,
  output logic        master_rd,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  input  logic        vctr_fifo_almost_full,
  output logic        vctr_fifo_wr,
  output logic [31:0] vctr_fifo_din,
  output logic        host_rdata_val,
  output logic        host_err,
  output logic [31:0] host_rdata,
  input  logic        clear_err,
  output logic        timeout_err,
  output logic [15:0] prog_fetch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Counter value seen on the last allowed WAIT cycle. The counter holds 0 on
  // the first WAIT cycle, so this is the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic                owner_host_q, owner_host_d;
  logic                last_gnt_host_q, last_gnt_host_d;
  logic [31:0]         addr_q, addr_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                vctr_fifo_wr_q, vctr_fifo_wr_d;
  logic [31:0]         vctr_fifo_din_q, vctr_fifo_din_d;
  logic                host_rdata_val_q, host_rdata_val_d;
  logic                host_err_q, host_err_d;
  logic [31:0]         host_rdata_q, host_rdata_d;
  logic                timeout_err_q, timeout_err_d;
  logic [15:0]         prog_fetch_cnt_q, prog_fetch_cnt_d;

  logic prog_elig;
  logic host_elig;
  logic take_host;
  logic timeout_set;

  assign prog_elig = prog_req & run_en & ~vctr_fifo_almost_full;
  assign host_elig = host_req;

  // On a tie the requester that was not granted last wins.
  assign take_host = host_elig & (~prog_elig | ~last_gnt_host_q);

  always_comb begin
    state_d          = state_q;
    owner_host_d     = owner_host_q;
    last_gnt_host_d  = last_gnt_host_q;
    addr_d           = addr_q;
    to_cnt_d         = to_cnt_q;
    vctr_fifo_wr_d   = 1'b0;
    vctr_fifo_din_d  = vctr_fifo_din_q;
    host_rdata_val_d = 1'b0;
    host_err_d       = 1'b0;
    host_rdata_d     = host_rdata_q;
    prog_fetch_cnt_d = prog_fetch_cnt_q;
    timeout_set      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The winner is decided here so ISSUE can present the address and
        // grant in the very next cycle; last_gnt moves with every grant.
        if (prog_elig | host_elig) begin
          owner_host_d    = take_host;
          last_gnt_host_d = take_host;
          addr_d          = take_host ? host_addr : prog_addr;
          state_d         = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        // Data wins over timeout when both land on the last allowed cycle.
        if (master_data_in_val) begin
          if (owner_host_q) begin
            host_rdata_val_d = 1'b1;
            host_rdata_d     = master_data_in;
          end else begin
            vctr_fifo_wr_d   = 1'b1;
            vctr_fifo_din_d  = master_data_in;
            prog_fetch_cnt_d = prog_fetch_cnt_q + 16'd1;
          end
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set = 1'b1;
          if (owner_host_q) begin
            host_rdata_val_d = 1'b1;
            host_err_d       = 1'b1;
            host_rdata_d     = 32'h0;
          end
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A timeout in the same cycle as clear_err leaves the flag set.
    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (clear_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      owner_host_q     <= 1'b0;
      last_gnt_host_q  <= 1'b1;
      addr_q           <= 32'h0;
      to_cnt_q         <= '0;
      vctr_fifo_wr_q   <= 1'b0;
      vctr_fifo_din_q  <= 32'h0;
      host_rdata_val_q <= 1'b0;
      host_err_q       <= 1'b0;
      host_rdata_q     <= 32'h0;
      timeout_err_q    <= 1'b0;
      prog_fetch_cnt_q <= 16'h0;
    end else begin
      state_q          <= state_d;
      owner_host_q     <= owner_host_d;
      last_gnt_host_q  <= last_gnt_host_d;
      addr_q           <= addr_d;
      to_cnt_q         <= to_cnt_d;
      vctr_fifo_wr_q   <= vctr_fifo_wr_d;
      vctr_fifo_din_q  <= vctr_fifo_din_d;
      host_rdata_val_q <= host_rdata_val_d;
      host_err_q       <= host_err_d;
      host_rdata_q     <= host_rdata_d;
      timeout_err_q    <= timeout_err_d;
      prog_fetch_cnt_q <= prog_fetch_cnt_d;
    end
  end

  // addr_q only changes on the way into ISSUE, so outside ISSUE it still
  // shows the last issued address.
  assign master_rd      = (state_q == ST_ISSUE);
  assign prog_gnt       = master_rd & ~owner_host_q;
  assign host_gnt       = master_rd & owner_host_q;
  assign master_addr    = addr_q;
  assign vctr_fifo_wr   = vctr_fifo_wr_q;
  assign vctr_fifo_din  = vctr_fifo_din_q;
  assign host_rdata_val = host_rdata_val_q;
  assign host_err       = host_err_q;
  assign host_rdata     = host_rdata_q;
  assign timeout_err    = timeout_err_q;
  assign prog_fetch_cnt = prog_fetch_cnt_q;

endmodule
